fifo_sink_checker: RTL and testbench
====================================

# fifo_sink_checker

Dequeue-side consumer and checker for the `Fifo` bench. It attaches to the Fifo's `deqRdy`/`deqEn`/`deqVal` port and drains it under pseudo-random backpressure. Every accepted word is checked against an expected modulo-2^WIDTH incrementing sequence, and the block reports progress and error counts. It is the receiving end of the incrementing-value producer that drives the enqueue side, which together close the loop for self-checking Fifo regressions.

## Interface
- `WIDTH`, 1: data width of the dequeue value; must match the Fifo's `width`.
- `NUM_ITEMS`, 0: number of words to accept before entering DONE; 0 means run forever.
- `STALL_MASK`, 8'h00: stall-pattern AND mask over the LFSR; 0 means never stall.
- `SEED`, 8'h5A: LFSR reset value; must be nonzero.
- `STOP_ON_ERR`, 0: when 1, the first mismatch moves the block to HALT.
- `CNT_W`, 16: width of `rx_count` and `err_count`.

Ports:
- `clk`  in  1  clock; all state updates on the posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `deq_rdy`  in  1  Fifo has a word available.
- `deq_en`  out  1  dequeue strobe; a transfer occurs in any cycle where `deq_rdy && deq_en`.
- `deq_val`  in  WIDTH  Fifo head word; valid when `deq_rdy` = 1.
- `rx_count`  out  CNT_W  words accepted; wraps modulo 2^CNT_W.
- `err_count`  out  CNT_W  mismatches; saturates at all-ones.
- `err`  out  1  sticky; set on the first mismatch.
- `first_bad`  out  WIDTH  `deq_val` of the first mismatch.
- `done`  out  1  high in DONE state.
- `halted`  out  1  high in HALT state.

## Operation
- FSM states: IDLE, RUN, DONE, HALT. Reset goes to IDLE.
- IDLE → RUN unconditionally after one cycle. This gives the Fifo a settle cycle after reset.
- RUN → DONE when an acceptance makes the accepted-word total equal NUM_ITEMS (only when NUM_ITEMS ≠ 0).
- RUN → HALT on a mismatch when STOP_ON_ERR = 1.
  - If the mismatch is also the NUM_ITEMSth word, HALT wins.
- DONE and HALT are terminal until reset.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle when `rst_n` = 1, in all states.
- `stall = |(lfsr & STALL_MASK)`.
- `deq_en = rst_n && state==RUN && deq_rdy && !stall`.
  - Combinational from `deq_rdy`. The Fifo's `deqRdy` must not depend on `deqEn`, so no loop exists.
- Expected-value register `exp`, WIDTH bits, resets to 0. On acceptance:
  - Match (`deq_val == exp`): `exp <= exp+1` (wraps mod 2^WIDTH).
  - Mismatch: `err_count` increments (saturating), `exp <= deq_val+1` (resync). A single dropped or duplicated word therefore costs exactly one error.
  - First mismatch only: `err` is set and `first_bad <= deq_val`.
- `rx_count` increments on every acceptance, including mismatched ones.
- No acceptance, and no state change other than the LFSR advance, occurs when `deq_rdy` = 0, when stalled, or outside RUN.

## Timing
- Reset values while `rst_n` = 0 at an edge:
  - state = IDLE, `exp` = 0, `rx_count` = 0, `err_count` = 0, `err` = 0, `first_bad` = 0, `done` = 0, `halted` = 0, `lfsr` = SEED.
  - `deq_en` = 0 combinationally for the whole time `rst_n` is low.
- Reset mid-operation (any state) behaves identically to power-on reset. No word is accepted in a cycle where `rst_n` = 0.
- First possible acceptance is the second cycle after `rst_n` rises; the first cycle is IDLE.
- Zero-latency handshake: a transfer completes in the same cycle `deq_en` and `deq_rdy` are both high.
  - Counters, `err` and `first_bad` are visible in the cycle after the accepting edge.
- `done` and `halted` rise in the cycle after the terminating acceptance. `deq_en` is 0 from that cycle on.
- Back-to-back acceptance every cycle is supported when STALL_MASK = 0.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `deq_rdy` = 1 → `deq_en` = 0 throughout, all counts 0, `err` = 0; first `deq_en` = 1 on the 2nd cycle after release.
- Clean drain: WIDTH=4, NUM_ITEMS=4, mask 0, `deq_rdy` = 1 with head values 0,1,2,3 → 4 consecutive acceptances, `rx_count` = 4, `err_count` = 0, `done` = 1 the next cycle, `deq_en` = 0 thereafter.
- Drop detection: stream 0,1,3,4,5 → `err_count` = 1, `err` = 1, `first_bad` = 3, no further errors, `rx_count` = 5.
- Wrap: WIDTH=2, stream 0,1,2,3,0,1 → `err_count` = 0, `rx_count` = 6.
- Stop on error plus reset mid-operation: STOP_ON_ERR=1, stream 0,2 → `halted` = 1 the next cycle and `deq_en` stays 0 with `deq_rdy` = 1. Then pulse `rst_n` low one cycle → all outputs back to reset values, and the block resumes accepting 0,1.
- Backpressure: STALL_MASK=8'h01, SEED=8'h5A, `deq_rdy` = 1 → every cycle in RUN, `deq_en == !lfsr[0]`, matching a reference LFSR model. Over 64 cycles, `rx_count` equals the number of cycles with `lfsr[0]` = 0.

Source files
------------

// File: rtl/fifo_sink_checker.sv
// Dequeue-side consumer for Fifo regressions: drains under LFSR backpressure and
// checks every accepted word against an incrementing modulo-2^WIDTH sequence.
module fifo_sink_checker #(
  parameter int         WIDTH       = 1,
  parameter int         NUM_ITEMS   = 0,
  parameter logic [7:0] STALL_MASK  = 8'h00,
  parameter logic [7:0] SEED        = 8'h5A,
  parameter bit         STOP_ON_ERR = 1'b0,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             deq_rdy,
  output logic             deq_en,
  input  logic [WIDTH-1:0] deq_val,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err,
  output logic [WIDTH-1:0] first_bad,
  output logic             done,
  output logic             halted,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_ITEMS);
  localparam logic [WIDTH-1:0] VAL_ONE   = WIDTH'(1);
  localparam bit               HAS_LIMIT = (NUM_ITEMS != 0);

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [7:0]       lfsr;
  logic             lfsrFb;
  logic [WIDTH-1:0] expVal;
  logic             stall;
  logic             accept;
  logic             mismatch;
  logic             lastItem;
  logic [CNT_W-1:0] rxNext;

  // Handshake: a word moves in any cycle where deq_rdy && deq_en. deq_rdy must not
  // depend on deq_en; deq_en is combinational from deq_rdy and is zero during reset.
  assign stall    = |(lfsr & STALL_MASK);
  assign deq_en   = rst_n && (state == RUN) && deq_rdy && !stall;
  assign accept   = deq_en;
  assign mismatch = accept && (deq_val != expVal);
  assign rxNext   = rx_count + CNT_ONE;
  assign lastItem = HAS_LIMIT && (rxNext == CNT_LAST);

  // Taps x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsrFb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign done      = (state == DONE);
  assign halted    = (state == HALT);
  assign dbg_state = state;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = RUN;
      RUN: begin
        // A mismatch on the final word still halts rather than completing.
        if (mismatch && STOP_ON_ERR)
          stateNext = HALT;
        else if (accept && lastItem)
          stateNext = DONE;
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      expVal    <= '0;
      rx_count  <= '0;
      err_count <= '0;
      err       <= 1'b0;
      first_bad <= '0;
    end else begin
      state <= stateNext;
      lfsr  <= {lfsr[6:0], lfsrFb};
      if (accept) begin
        rx_count <= rxNext;
        if (mismatch) begin
          // Resync to the received word so one drop or duplicate costs one error.
          expVal <= deq_val + VAL_ONE;
          if (err_count != '1)
            err_count <= err_count + CNT_ONE;
          if (!err) begin
            err       <= 1'b1;
            first_bad <= deq_val;
          end
        end else begin
          expVal <= expVal + VAL_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_sink_checker.sv
// Directed bench for fifo_sink_checker: five instances cover reset, clean drain,
// drop detection, wrap, stop-on-error with mid-run reset, and LFSR backpressure.
module tb_fifo_sink_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [4:0]  rdy;
  logic [4:0]  en;
  logic [4:0]  errv;
  logic [4:0]  done;
  logic [4:0]  halted;
  logic [3:0]  val  [5];
  logic [15:0] rxc  [5];
  logic [15:0] errc [5];
  logic [3:0]  fbad [5];
  logic [1:0]  st   [5];
  logic [1:0]  fbadC;

  logic [3:0] stim_q[$];
  logic       exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign fbad[2] = {2'b00, fbadC};

  fifo_sink_checker #(.WIDTH(4), .NUM_ITEMS(4)) u_drain (
    .clk(clk), .rst_n(rst_n), .deq_rdy(rdy[0]), .deq_en(en[0]), .deq_val(val[0]),
    .rx_count(rxc[0]), .err_count(errc[0]), .err(errv[0]), .first_bad(fbad[0]),
    .done(done[0]), .halted(halted[0]), .dbg_state(st[0]));

  fifo_sink_checker #(.WIDTH(4)) u_drop (
    .clk(clk), .rst_n(rst_n), .deq_rdy(rdy[1]), .deq_en(en[1]), .deq_val(val[1]),
    .rx_count(rxc[1]), .err_count(errc[1]), .err(errv[1]), .first_bad(fbad[1]),
    .done(done[1]), .halted(halted[1]), .dbg_state(st[1]));

  fifo_sink_checker #(.WIDTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .deq_rdy(rdy[2]), .deq_en(en[2]), .deq_val(val[2][1:0]),
    .rx_count(rxc[2]), .err_count(errc[2]), .err(errv[2]), .first_bad(fbadC),
    .done(done[2]), .halted(halted[2]), .dbg_state(st[2]));

  fifo_sink_checker #(.WIDTH(4), .STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .deq_rdy(rdy[3]), .deq_en(en[3]), .deq_val(val[3]),
    .rx_count(rxc[3]), .err_count(errc[3]), .err(errv[3]), .first_bad(fbad[3]),
    .done(done[3]), .halted(halted[3]), .dbg_state(st[3]));

  fifo_sink_checker #(.WIDTH(4), .STALL_MASK(8'h01), .SEED(8'h5A)) u_bp (
    .clk(clk), .rst_n(rst_n), .deq_rdy(rdy[4]), .deq_en(en[4]), .deq_val(val[4]),
    .rx_count(rxc[4]), .err_count(errc[4]), .err(errv[4]), .first_bad(fbad[4]),
    .done(done[4]), .halted(halted[4]), .dbg_state(st[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Leaves the bench at the negedge where rst_n rises, i.e. the IDLE cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rdy   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents stim_q one word per cycle from a RUN-cycle negedge; each must be taken.
  task automatic feed(input int idx);
    foreach (stim_q[i]) begin
      rdy[idx] = 1'b1;
      val[idx] = stim_q[i];
      #1 chk($sformatf("en%0d_w%0d", idx, i), 32'(en[idx]), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] m;
    int         expAcc;
    int         accCnt;
    rdy = '0;
    for (int i = 0; i < 5; i++) val[i] = '0;

    // Reset held low with the Fifo offering data.
    rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_en_%0d", i), 32'(en[0]), 32'd0);
    end
    chk("rst_rx",     32'(rxc[0]),  32'd0);
    chk("rst_errc",   32'(errc[0]), 32'd0);
    chk("rst_err",    32'(errv[0]), 32'd0);
    chk("rst_fbad",   32'(fbad[0]), 32'd0);
    chk("rst_done",   32'(done[0]), 32'd0);
    chk("rst_halted", 32'(halted[0]), 32'd0);
    chk("rst_state",  32'(st[0]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle_en", 32'(en[0]), 32'd0);
    @(negedge clk);

    // Clean drain of four words, then DONE.
    stim_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    feed(0);
    #1;
    chk("drain_done",  32'(done[0]), 32'd1);
    chk("drain_rx",    32'(rxc[0]),  32'd4);
    chk("drain_errc",  32'(errc[0]), 32'd0);
    chk("drain_en",    32'(en[0]),   32'd0);
    @(negedge clk);
    #1 chk("drain_en2", 32'(en[0]), 32'd0);
    chk("drain_rx2", 32'(rxc[0]), 32'd4);
    rdy[0] = 1'b0;

    // Dropped word 2: one error, then resynced.
    do_reset();
    @(negedge clk);
    stim_q = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5};
    feed(1);
    rdy[1] = 1'b0;
    #1;
    chk("drop_errc", 32'(errc[1]), 32'd1);
    chk("drop_err",  32'(errv[1]), 32'd1);
    chk("drop_fbad", 32'(fbad[1]), 32'd3);
    chk("drop_rx",   32'(rxc[1]),  32'd5);

    // Two-bit wrap is not an error.
    do_reset();
    @(negedge clk);
    stim_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    feed(2);
    rdy[2] = 1'b0;
    #1;
    chk("wrap_errc", 32'(errc[2]), 32'd0);
    chk("wrap_err",  32'(errv[2]), 32'd0);
    chk("wrap_rx",   32'(rxc[2]),  32'd6);

    // Stop on error, then a one-cycle reset pulse and resume.
    do_reset();
    @(negedge clk);
    stim_q = '{4'd0, 4'd2};
    feed(3);
    #1;
    chk("halt_halted", 32'(halted[3]), 32'd1);
    chk("halt_en",     32'(en[3]),     32'd0);
    chk("halt_errc",   32'(errc[3]),   32'd1);
    chk("halt_err",    32'(errv[3]),   32'd1);
    chk("halt_fbad",   32'(fbad[3]),   32'd2);
    chk("halt_rx",     32'(rxc[3]),    32'd2);
    chk("halt_state",  32'(st[3]),     32'd3);
    chk("halt_done",   32'(done[3]),   32'd0);
    @(negedge clk);
    #1 chk("halt_en2", 32'(en[3]), 32'd0);
    chk("halt_halted2", 32'(halted[3]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("pulse_en_low", 32'(en[3]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pulse_halted", 32'(halted[3]), 32'd0);
    chk("pulse_rx",     32'(rxc[3]),    32'd0);
    chk("pulse_errc",   32'(errc[3]),   32'd0);
    chk("pulse_err",    32'(errv[3]),   32'd0);
    chk("pulse_fbad",   32'(fbad[3]),   32'd0);
    chk("pulse_state",  32'(st[3]),     32'd0);
    chk("pulse_idle_en", 32'(en[3]),    32'd0);
    @(negedge clk);
    stim_q = '{4'd0, 4'd1};
    feed(3);
    rdy[3] = 1'b0;
    #1;
    chk("resume_rx",   32'(rxc[3]),  32'd2);
    chk("resume_errc", 32'(errc[3]), 32'd0);
    chk("resume_err",  32'(errv[3]), 32'd0);

    // Backpressure against a reference LFSR; first RUN cycle sees one advance.
    do_reset();
    m = 8'h5A;
    m = lfsr_next(m);
    expAcc = 0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(!m[0]);
      if (!m[0]) expAcc++;
      m = lfsr_next(m);
    end
    @(negedge clk);
    accCnt = 0;
    for (int i = 0; i < 64; i++) begin
      logic want;
      want = exp_q.pop_front();
      rdy[4] = 1'b1;
      val[4] = 4'(accCnt);
      #1 chk($sformatf("bp_en_c%0d", i), 32'(en[4]), 32'(want));
      if (want) accCnt++;
      @(negedge clk);
    end
    rdy[4] = 1'b0;
    #1;
    chk("bp_rx",   32'(rxc[4]),  32'(expAcc));
    chk("bp_errc", 32'(errc[4]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
